// File: rtl/vedic_seq_pkg.sv
// rtl/vedic_seq_pkg.sv - shared types and schedule helpers for the sequential vedic multiplier
package vedic_seq_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DONE} seq_state_t;

  typedef logic [1:0] pp_idx_t;

  // Left shift applied to partial product idx before it joins the accumulator.
  // idx bit1 selects the high half of a, idx bit0 the high half of b.
  function automatic int pp_shift(pp_idx_t idx, int width);
    case (idx)
      2'd0:    return 0;
      2'd3:    return width;
      default: return width / 2;
    endcase
  endfunction

  // Lowest set index of a 4-entry partial-product mask (3 when only bit 3 or none is set).
  function automatic pp_idx_t lowest_idx(logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

endpackage

// File: rtl/vedic_mult_seq_ctrl_if.sv
// rtl/vedic_mult_seq_ctrl_if.sv - operand/result handshake bundle for vedic_mult_seq_ctrl
interface vedic_mult_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out;
  logic               busy;

  // Producer/consumer side of the block.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out, busy
  );

  // The sequencer itself.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/vedic_mult.sv
// rtl/vedic_mult.sv - combinational unsigned vedic multiplier, recursive down to a 2x2 gate cell
module vedic_mult #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  if (WIDTH == 2) begin : g_base
    logic c;
    // 2x2 cell: vertical and crosswise terms built from plain gates
    assign p[0] = a[0] & b[0];
    assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign c    = (a[1] & b[0]) & (a[0] & b[1]);
    assign p[2] = (a[1] & b[1]) ^ c;
    assign p[3] = (a[1] & b[1]) & c;
  end else begin : g_rec
    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;
    logic [WIDTH-1:0] ll, lh, hl, hh;

    vedic_mult #(.WIDTH(H)) u_ll (.a(a[H-1:0]),     .b(b[H-1:0]),     .p(ll));
    vedic_mult #(.WIDTH(H)) u_lh (.a(a[H-1:0]),     .b(b[WIDTH-1:H]), .p(lh));
    vedic_mult #(.WIDTH(H)) u_hl (.a(a[WIDTH-1:H]), .b(b[H-1:0]),     .p(hl));
    vedic_mult #(.WIDTH(H)) u_hh (.a(a[WIDTH-1:H]), .b(b[WIDTH-1:H]), .p(hh));

    // Crosswise terms land at H, the high-high term at WIDTH; the sum fits in PW bits.
    assign p = PW'(ll) + (PW'(lh) << H) + (PW'(hl) << H) + (PW'(hh) << WIDTH);
  end

endmodule

// File: rtl/vedic_mult_seq_ctrl.sv
// rtl/vedic_mult_seq_ctrl.sv - WIDTHxWIDTH multiply via four passes through one HALF-width vedic_mult; VEDIC_SEQ_ZERO_SKIP_EN skips zero partial products
module vedic_mult_seq_ctrl
  import vedic_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  vedic_mult_seq_ctrl_if.slave bus
);

  localparam int HALF = WIDTH / 2;
  localparam int PW   = 2 * WIDTH;

  seq_state_t       state, state_nx;
  pp_idx_t          idx, first_idx, next_idx;
  logic [WIDTH-1:0] op_a, op_b;
  logic [PW-1:0]    acc, pp_term;
  logic [HALF-1:0]  mul_a, mul_b;
  logic [WIDTH-1:0] pp;
  logic             accept, last_step, start_empty;

  // Shared multiplier sees only the captured operands, never the live bus.
  assign mul_a = idx[1] ? op_a[WIDTH-1:HALF] : op_a[HALF-1:0];
  assign mul_b = idx[0] ? op_b[WIDTH-1:HALF] : op_b[HALF-1:0];

  vedic_mult #(.WIDTH(HALF)) u_mul (.a(mul_a), .b(mul_b), .p(pp));

  assign pp_term = PW'(pp) << pp_shift(idx, WIDTH);

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
  logic [3:0] mask, in_mask, remaining;

  // Partial products whose both operand halves are nonzero for the incoming pair
  always_comb begin
    in_mask[0] = (bus.a[HALF-1:0] != '0)     && (bus.b[HALF-1:0] != '0);
    in_mask[1] = (bus.a[HALF-1:0] != '0)     && (bus.b[WIDTH-1:HALF] != '0);
    in_mask[2] = (bus.a[WIDTH-1:HALF] != '0) && (bus.b[HALF-1:0] != '0);
    in_mask[3] = (bus.a[WIDTH-1:HALF] != '0) && (bus.b[WIDTH-1:HALF] != '0);
  end

  assign remaining   = mask & (4'b1110 << idx);
  assign first_idx   = lowest_idx(in_mask);
  assign next_idx    = lowest_idx(remaining);
  assign last_step   = (remaining == 4'b0000);
  assign start_empty = (in_mask == 4'b0000);

  // Mask is frozen at accept so later bus changes cannot alter the schedule
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         mask <= 4'b0000;
    else if (accept) mask <= in_mask;
  end
`else
  assign first_idx   = 2'd0;
  assign next_idx    = idx + 2'd1;
  assign last_step   = (idx == 2'd3);
  assign start_empty = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs; DONE never accepts in its release cycle
  always_comb begin
    state_nx      = state;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) begin
          accept   = 1'b1;
          state_nx = start_empty ? DONE : MUL;
        end
      end
      MUL: begin
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture and shift-accumulate of one partial product per MUL cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
      acc  <= '0;
      idx  <= 2'd0;
    end else if (accept) begin
      op_a <= bus.a;
      op_b <= bus.b;
      acc  <= '0;
      idx  <= first_idx;
    end else if (state == MUL) begin
      acc <= acc + pp_term;
      idx <= next_idx;
    end
  end

  assign bus.out = acc;

endmodule

// File: tb/tb_vedic_mult_seq_ctrl.sv
// tb/tb_vedic_mult_seq_ctrl.sv - self-checking bench for vedic_mult_seq_ctrl
module tb_vedic_mult_seq_ctrl;

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_delivered = 0;

  // Abstract model: 0 idle, 1 working, 2 result waiting
  int          m_phase = 0;
  int          m_left = 0;
  logic [63:0] m_result = '0;

  vedic_mult_seq_ctrl_if #(.WIDTH(32)) bus();

  vedic_mult_seq_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Edges after the accept edge until the result is offered
  function automatic int exp_lat(logic [31:0] x, logic [31:0] y);
    int n;
    n = 4;
    if (ZS) begin
      n = 0;
      if (x[15:0]  != 0 && y[15:0]  != 0) n++;
      if (x[15:0]  != 0 && y[31:16] != 0) n++;
      if (x[31:16] != 0 && y[15:0]  != 0) n++;
      if (x[31:16] != 0 && y[31:16] != 0) n++;
    end
    return n;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [15:0] lo, hi;
    lo = 16'($urandom);
    hi = 16'($urandom);
    if ($urandom_range(0, 3) == 0) lo = 16'h0;
    if ($urandom_range(0, 3) == 0) hi = 16'h0;
    return {hi, lo};
  endfunction

  // Per-cycle comparison against the model, then model advance for the next edge
  always @(negedge clk) begin
    if (rst) begin
      m_phase = 0;
    end else begin
      chk("in_ready",  64'(bus.in_ready),  64'(m_phase == 0));
      chk("out_valid", 64'(bus.out_valid), 64'(m_phase == 2));
      chk("busy",      64'(bus.busy),      64'(m_phase != 0));
      if (m_phase == 2) chk("out_model", bus.out, m_result);
      case (m_phase)
        0: if (bus.in_valid) begin
             m_result = 64'(bus.a) * 64'(bus.b);
             m_left   = exp_lat(bus.a, bus.b);
             m_phase  = (m_left == 0) ? 2 : 1;
           end
        1: begin
             m_left--;
             if (m_left == 0) m_phase = 2;
           end
        default: if (bus.out_ready) begin
             m_phase = 0;
             n_delivered++;
           end
      endcase
    end
  end

  task automatic do_txn(input logic [31:0] ta, input logic [31:0] tbv, input logic [63:0] exp,
                        input int lat, input int hold, input string nm);
    int t;
    bus.a = ta;
    bus.b = tbv;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    t = 0;
    while (!bus.in_ready && t < 20) begin @(posedge clk); #1; t++; end
    chk({nm, "_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 32'hDEAD_BEEF;
    bus.b = 32'h0BAD_F00D;
    t = 0;
    while (!bus.out_valid && t < 20) begin @(posedge clk); #1; t++; end
    chk({nm, "_lat"}, 64'(t), 64'(lat));
    chk({nm, "_out"}, bus.out, exp);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = ~bus.in_valid;
      @(posedge clk); #1;
      chk({nm, "_hold_out"}, bus.out, exp);
      chk({nm, "_hold_vld"}, 64'(bus.out_valid), 64'd1);
      chk({nm, "_hold_rdy"}, 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({nm, "_vld_clr"}, 64'(bus.out_valid), 64'd0);
    chk({nm, "_rdy_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual running required done");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_out",       bus.out,            64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4, 0, "max");
    do_txn(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, ZS ? 1 : 4, 0, "hihi");
    do_txn(32'h1234_5678, 32'h9ABC_DEF0, 64'(32'h1234_5678) * 64'(32'h9ABC_DEF0), 4, 3, "mixed_bp");
    do_txn(32'd5, 32'd7, 64'd35, ZS ? 1 : 4, 0, "small");
    do_txn(32'd0, 32'h1234_5678, 64'd0, ZS ? 0 : 4, 0, "zero");

    // Reset while the third partial product is pending
    bus.a = 32'h0003_0003;
    bus.b = 32'h0005_0005;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_busy",      64'(bus.busy),      64'd0);
    chk("mid_rst_out",       bus.out,            64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_txn(32'd3, 32'd4, 64'd12, ZS ? 1 : 4, 0, "after_rst");

    base = n_delivered;
    fork
      begin : producer
        bit got;
        int tp;
        for (int n = 0; n < 1000; n++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          bus.a = rnd_op();
          bus.b = rnd_op();
          bus.in_valid = 1'b1;
          tp = 0;
          got = 1'b0;
          while (!got && tp < 100) begin
            got = bus.in_ready;
            @(posedge clk); #1;
            tp++;
          end
          bus.in_valid = 1'b0;
          if (!got) chk("rand_accept_timeout", 64'(got), 64'd1);
        end
      end
      begin : consumer
        int tc;
        tc = 0;
        while (n_delivered - base < 1000 && tc < 60000) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          tc++;
        end
        bus.out_ready = 1'b0;
      end
    join
    @(posedge clk); #1;
    chk("rand_delivered", 64'(n_delivered - base), 64'd1000);
    chk("rand_idle", 64'(bus.busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
